rptr_empty_sync: RTL and testbench

Read-domain half of the dual-clock FIFO; generalised successor to the basic two-flop write-pointer synchroniser.
- Brings the Gray-coded write pointer into rclk through a configurable-depth synchroniser chain.
- Owns the read pointer (binary and Gray).
- Generates registered empty, almost-empty and fill-level status for the downstream consumer.

---
 rtl/rptr_empty_sync.sv | 97 +++++++++
 tb/tb_rptr_empty_sync.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_sync.sv
// Read-domain half of a dual-clock FIFO: write-pointer synchroniser, read pointer, empty/level flags.
// Optional build macro RPTR_GRAY_CHECK_EN enables the sticky Gray-violation detector on rgray_err.
module rptr_empty_sync #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   wptr_gray,
  input  logic             rinc,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr_gray,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel,
  output logic             rgray_err
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("rptr_empty_sync: SYNC_STAGES must be in 2..4");
    end
    if (AE_THRESH < 0 || AE_THRESH > (1 << ASIZE)) begin : g_bad_thresh
      $error("rptr_empty_sync: AE_THRESH must be in 0..2**ASIZE");
    end
  endgenerate

  localparam logic [ASIZE:0] AE_LIM = (ASIZE+1)'(AE_THRESH);

  logic [ASIZE:0] sync_q [SYNC_STAGES];
  logic [ASIZE:0] rq_wptr;
  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbin_next;
  logic [ASIZE:0] rgray_next;
  logic [ASIZE:0] rlevel_next;
  logic           pop;

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_wptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ASIZE; i++) wbin_s[i] = ^(rq_wptr >> i);
  end

  assign pop         = rinc & ~rempty;
  assign rbin_next   = rbin + (ASIZE+1)'(pop);
  assign rgray_next  = (rbin_next >> 1) ^ rbin_next;
  assign rlevel_next = wbin_s - rbin_next;

  // Flags are computed from the post-pop pointer so the last pop raises rempty on the same edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbin_next;
      rptr_gray     <= rgray_next;
      rempty        <= (rgray_next == rq_wptr);
      ralmost_empty <= (rlevel_next <= AE_LIM);
      rlevel        <= rlevel_next;
    end
  end

  assign raddr = rbin[ASIZE-1:0];

`ifdef RPTR_GRAY_CHECK_EN
  logic [ASIZE:0] rq_prev;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq_prev   <= '0;
      rgray_err <= 1'b0;
    end else begin
      rq_prev <= rq_wptr;
      if ($countones(rq_wptr ^ rq_prev) > 1) rgray_err <= 1'b1;
    end
  end
`else
  assign rgray_err = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_sync.sv
// Bench for rptr_empty_sync: two instances (2 and 3 sync stages) against a pointer-arithmetic model.
module tb_rptr_empty_sync;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [4:0] wptr_gray = '0;
  logic       rinc = 1'b0;

  logic [3:0] raddr_a, raddr_b;
  logic [4:0] rptr_gray_a, rptr_gray_b, rlevel_a, rlevel_b;
  logic       rempty_a, rempty_b, rae_a, rae_b, rerr_a, rerr_b;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

`ifdef RPTR_GRAY_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  always #5 rclk = ~rclk;

  rptr_empty_sync #(.ASIZE(4), .SYNC_STAGES(2), .AE_THRESH(2)) dut_a (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rinc(rinc),
    .raddr(raddr_a), .rptr_gray(rptr_gray_a), .rempty(rempty_a),
    .ralmost_empty(rae_a), .rlevel(rlevel_a), .rgray_err(rerr_a));

  rptr_empty_sync #(.ASIZE(4), .SYNC_STAGES(3), .AE_THRESH(2)) dut_b (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rinc(rinc),
    .raddr(raddr_b), .rptr_gray(rptr_gray_b), .rempty(rempty_b),
    .ralmost_empty(rae_b), .rlevel(rlevel_b), .rgray_err(rerr_b));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Binary value whose Gray code is g, found by search rather than by bit formula.
  function automatic int gray_to_bin(input int g);
    for (int v = 0; v < 32; v++) if (((v ^ (v >> 1)) & 31) == g) return v;
    return 0;
  endfunction

  function automatic int popcnt(input int x);
    int c = 0;
    for (int i = 0; i < 32; i++) c += (x >> i) & 1;
    return c;
  endfunction

  // Model: rq_wptr before edge n is the write pointer sampled S edges earlier.
  int hist [64];
  int ecount = 0;
  int rbin_m [2];
  int lvl_m [2];
  bit err_m [2];

  function automatic int hist_at(input int k);
    return (k < 0) ? 0 : hist[k & 63];
  endfunction

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ecount = 0;
      for (int i = 0; i < 2; i++) begin
        rbin_m[i] = 0; lvl_m[i] = 0; err_m[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int s, rq, rqp;
        s   = (i == 0) ? 2 : 3;
        rq  = hist_at(ecount - s);
        rqp = hist_at(ecount - s - 1);
        if (rinc && lvl_m[i] != 0) rbin_m[i] = (rbin_m[i] + 1) & 31;
        lvl_m[i] = (gray_to_bin(rq) - rbin_m[i]) & 31;
        if (ERR_ON && popcnt(rq ^ rqp) > 1) err_m[i] = 1'b1;
      end
      hist[ecount & 63] = int'(wptr_gray);
      ecount++;
    end
  end

  always @(negedge rclk) begin
    if (check_en && rrst_n) begin
      chk("a.raddr",  int'(raddr_a),     rbin_m[0] & 15);
      chk("a.rgray",  int'(rptr_gray_a), (rbin_m[0] ^ (rbin_m[0] >> 1)) & 31);
      chk("a.rlevel", int'(rlevel_a),    lvl_m[0]);
      chk("a.rempty", int'(rempty_a),    int'(lvl_m[0] == 0));
      chk("a.rae",    int'(rae_a),       int'(lvl_m[0] <= 2));
      chk("a.rerr",   int'(rerr_a),      int'(err_m[0]));
      chk("b.raddr",  int'(raddr_b),     rbin_m[1] & 15);
      chk("b.rgray",  int'(rptr_gray_b), (rbin_m[1] ^ (rbin_m[1] >> 1)) & 31);
      chk("b.rlevel", int'(rlevel_b),    lvl_m[1]);
      chk("b.rempty", int'(rempty_b),    int'(lvl_m[1] == 0));
      chk("b.rae",    int'(rae_b),       int'(lvl_m[1] <= 2));
      chk("b.rerr",   int'(rerr_b),      int'(err_m[1]));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".a.rempty"}, int'(rempty_a), 1);
    chk({tag, ".a.rae"},    int'(rae_a), 1);
    chk({tag, ".a.rlevel"}, int'(rlevel_a), 0);
    chk({tag, ".a.raddr"},  int'(raddr_a), 0);
    chk({tag, ".a.rgray"},  int'(rptr_gray_a), 0);
    chk({tag, ".a.rerr"},   int'(rerr_a), 0);
    chk({tag, ".b.rempty"}, int'(rempty_b), 1);
    chk({tag, ".b.rlevel"}, int'(rlevel_b), 0);
    chk({tag, ".b.raddr"},  int'(raddr_b), 0);
    chk({tag, ".b.rgray"},  int'(rptr_gray_b), 0);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0; rinc = 1'b0; wptr_gray = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  initial begin
    int ea, eb, pops, prev_lvl, wbin;

    // Reset holds everything while the write pointer moves.
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      wptr_gray = 5'(i * 3 + 1);
      #1 chk_reset_vals("reset");
    end
    wptr_gray = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
    check_en = 1'b1;

    // Latency: 0 -> 1 shows up after SYNC_STAGES+1 edges.
    tick(2);
    wptr_gray = 5'h01;
    ea = -1; eb = -1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge rclk); #1;
      if (ea < 0 && !rempty_a) ea = e;
      if (eb < 0 && !rempty_b) eb = e;
    end
    chk("lat.a", ea, 3);
    chk("lat.b", eb, 4);
    chk("lat.level", int'(rlevel_b), 1);

    // Fill to 16 entries and drain with rinc held for 20 cycles.
    do_reset();
    wptr_gray = 5'h18;
    tick(6);
    chk("fill.a.level", int'(rlevel_a), 16);
    chk("fill.b.level", int'(rlevel_b), 16);
    chk("fill.a.rae", int'(rae_a), 0);
    chk("fill.a.rempty", int'(rempty_a), 0);
    rinc = 1'b1;
    pops = 0;
    prev_lvl = 16;
    for (int j = 1; j <= 20; j++) begin
      @(negedge rclk);
      if (int'(rlevel_a) == prev_lvl - 1) pops++;
      prev_lvl = int'(rlevel_a);
      chk("drain.a.raddr",  int'(raddr_a),  (j < 16) ? j : 0);
      chk("drain.b.raddr",  int'(raddr_b),  (j < 16) ? j : 0);
      chk("drain.a.rempty", int'(rempty_a), int'(j >= 16));
      chk("drain.a.rae",    int'(rae_a),    int'(j >= 14));
    end
    chk("drain.pops", pops, 16);
    rinc = 1'b0;

    // Wrap: move rbin to 31, then wptr = Gray(1) and pop twice.
    wptr_gray = 5'h10;
    tick(6);
    rinc = 1'b1;
    tick(15);
    rinc = 1'b0;
    chk("wrap.raddr31", int'(raddr_a), 15);
    chk("wrap.rgray31", int'(rptr_gray_a), 5'h10);
    wptr_gray = 5'h01;
    tick(6);
    chk("wrap.level", int'(rlevel_a), 2);
    chk("wrap.rempty0", int'(rempty_a), 0);
    rinc = 1'b1;
    tick(1);
    chk("wrap.raddr0", int'(raddr_a), 0);
    chk("wrap.rgray0", int'(rptr_gray_a), 0);
    chk("wrap.rempty1", int'(rempty_a), 0);
    tick(1);
    chk("wrap.raddr1", int'(raddr_a), 1);
    chk("wrap.rgray1", int'(rptr_gray_a), 1);
    chk("wrap.rempty2", int'(rempty_a), 1);
    tick(1);
    chk("wrap.hold", int'(raddr_a), 1);
    rinc = 1'b0;

    // Gray check: 0x00 -> 0x03 is a two-bit jump.
    do_reset();
    wptr_gray = 5'h03;
    repeat (4) begin @(posedge rclk); #1; end
    chk("gchk.a", int'(rerr_a), int'(ERR_ON));
    chk("gchk.b", int'(rerr_b), int'(ERR_ON));
    tick(6);
    chk("gchk.sticky", int'(rerr_b), int'(ERR_ON));
    do_reset();
    #1 chk("gchk.clear", int'(rerr_a), 0);

    // Mid-operation reset acts before the next clock edge.
    wptr_gray = 5'h07;
    tick(6);
    chk("mid.level", int'(rlevel_a), 5);
    rinc = 1'b1;
    @(posedge rclk);
    #2 rrst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge rclk);
    rinc = 1'b0; wptr_gray = '0;
    rrst_n = 1'b1;

    // Randomised traffic with legal one-step Gray write pointer increments.
    do_reset();
    wbin = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge rclk);
      rinc = ($urandom_range(0, 9) < 5);
      if ($urandom_range(0, 9) < 4 &&
          ((wbin - rbin_m[0]) & 31) < 16 && ((wbin - rbin_m[1]) & 31) < 16) begin
        wbin = (wbin + 1) & 31;
        wptr_gray = 5'(wbin ^ (wbin >> 1));
      end
    end
    rinc = 1'b0;
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
